bsg_cache_nb_mshr_tracker: RTL and testbench
============================================

Name: bsg_cache_nb_mshr_tracker

Overview:
- Parametrised MSHR tracker for the non-blocking cache, between the tag-miss path and the DMA engine.
- Each entry holds a line address, a merged store-data buffer, byte-valid bits and a per-entry lifecycle FSM.
- Handles allocate/merge, miss issue, multi-beat refill with store-over-fill priority, and completed-line retirement.

Parameters:
- mshr_els_p, 4, number of entries (>=1).
- tag_width_p, 26, cache line address width.
- word_width_p, 32, word width in bits (multiple of 8).
- block_size_in_words_p, 8, words per line.
- fill_width_p, 64, refill beat width; line width (block_size_in_words_p*word_width_p) must be a multiple of it, and fill_width_p a multiple of 8.
- Derived: line_width_lp = block_size_in_words_p*word_width_p; beats_lp = line_width_lp/fill_width_p; lg_els_lp = BSG_SAFE_CLOG2(mshr_els_p).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- req_v_i  in  1  store/miss request valid.
- req_tag_i  in  tag_width_p  line address.
- req_word_i  in  BSG_SAFE_CLOG2(block_size_in_words_p)  word offset.
- req_data_i  in  word_width_p  store data.
- req_mask_i  in  word_width_p/8  byte mask (all-zero = load miss, allocate only).
- req_ready_o  out  1  request accepted this cycle.
- req_id_o  out  lg_els_lp  entry used (merged or allocated).
- miss_v_o  out  1  miss to issue.
- miss_id_o  out  lg_els_lp  entry id.
- miss_tag_o  out  tag_width_p  line address.
- miss_yumi_i  in  1  miss consumed.
- fill_v_i  in  1  refill beat valid (always accepted).
- fill_id_i  in  lg_els_lp  target entry.
- fill_data_i  in  fill_width_p  beat data.
- done_v_o  out  1  completed line available.
- done_id_o  out  lg_els_lp  entry id.
- done_tag_o  out  tag_width_p  line address.
- done_data_o  out  line_width_lp  merged line.
- done_yumi_i  in  1  line consumed; entry freed.
- empty_o  out  1  no entries busy.
- full_o  out  1  all entries busy.

Behaviour:
- Interface decided: one clock, clk_i; reset_i synchronous, active-high.
- Per-entry FSM: IDLE -> ALLOC (on allocate) -> PEND (miss_yumi_i) -> FILL (first beat) -> DONE (last beat) -> IDLE (done_yumi_i).
- Single-beat lines (beats_lp=1) go PEND -> DONE directly.
- Reset: all entries IDLE; valid bits, beat counter, data cleared; miss_v_o=done_v_o=full_o=0; empty_o=1; req_ready_o reflects combinational accept (1 when req_v_i and a free entry exists).
- Request, combinational match over entries in ALLOC/PEND/FILL with equal tag:
  - On match: req_ready_o=1; merge bytes next edge; req_id_o = matching id.
  - No match and an IDLE entry exists: allocate the lowest-index IDLE entry; store tag; merge bytes; ALLOC next cycle.
  - Tag matches an entry in DONE: req_ready_o=0 (stall until retired; no re-allocation of a live line).
  - No match and no IDLE entry: req_ready_o=0.
- Merge: byte b of word req_word_i written when req_mask_i[b]; matching valid bit set.
- miss_v_o: lowest-index entry in ALLOC; registered state only; a newly allocated entry is visible next cycle.
- Refill: one line in flight at a time; fill_id_i constant across a line's beats; an out-of-order id is a protocol error (not checked).
  - Shared beat counter 0..beats_lp-1; counter advances and wraps to 0 on the last beat.
  - Beat k covers line bits [k*fill_width_p +: fill_width_p]; only bytes with valid bit 0 are written; store data always wins.
  - Same-cycle fill beat and merge to the same entry: the merge byte wins on overlap; the fill writes the other bytes; valid bits end as the OR.
  - A fill beat to an entry not in PEND/FILL is ignored.
- done_v_o: lowest-index DONE entry. done_data_o is the full line.
  - done_yumi_i clears the entry's valid bits and returns it to IDLE next cycle.
  - The freed entry is not allocatable in the same cycle.
- empty_o / full_o derive from registered state.
- reset_i mid-fill: counter to 0 and all entries IDLE next edge; in-flight DMA data is dropped.

Optional Feature:
- Macro BSG_CACHE_NB_MSHR_TRACKER_STATS_EN.
- Defined: adds outputs stat_alloc_o [31:0], stat_merge_o [31:0], stat_stall_o [31:0].
  - Saturating counters of allocations, merges into existing entries, and cycles with req_v_i & ~req_ready_o.
  - Cleared by reset_i.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then req tag=0x100 word=2 data=0xDEADBEEF mask=4'hF -> req_id_o=0; next cycle miss_v_o=1, miss_tag_o=0x100, empty_o=0.
- Second req tag=0x100 word=5 mask=4'h3 before the fill -> merged into id 0, no new miss; after miss_yumi_i and 4 beats of 0xAAAA... -> done_data_o holds word2=0xDEADBEEF, word5 low half = store, rest 0xAA.
- Fill 4 entries with distinct tags -> full_o=1; 5th new tag -> req_ready_o=0 until done_yumi_i on id 0; allocation resumes the following cycle with id 0.
- Same-cycle merge to word 0 mask=4'h1 and fill beat 0 to the same entry -> byte 0 = store value, bytes 1..7 = fill.
- Req with a tag matching an entry in DONE -> req_ready_o=0; after done_yumi_i, the next cycle allocates a fresh entry and issues a new miss.
- Reset asserted after 2 of 4 beats -> all entries IDLE, empty_o=1; a new line refills from beat 0 correctly.

Source files
------------

// File: rtl/bsg_cache_nb_mshr_tracker.sv
// bsg_cache_nb_mshr_tracker: MSHR table between the tag-miss path and DMA.
// Entries hold line tag, merged store bytes and byte-valid bits; each walks
// IDLE -> ALLOC -> PEND -> FILL -> DONE -> IDLE.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_*                   store / load-miss request, accept and entry id
//   miss_*                  oldest-index entry waiting to issue its miss
//   fill_*                  refill beats from DMA, always accepted
//   done_*                  completed merged line, freed on done_yumi_i
//   empty_o, full_o         occupancy from registered state
//   stat_*_o                event counters, present only when the macro
//                           BSG_CACHE_NB_MSHR_TRACKER_STATS_EN is defined
module bsg_cache_nb_mshr_tracker
  #(parameter int mshr_els_p            = 4
   ,parameter int tag_width_p           = 26
   ,parameter int word_width_p          = 32
   ,parameter int block_size_in_words_p = 8
   ,parameter int fill_width_p          = 64
   ,localparam int line_width_lp = block_size_in_words_p*word_width_p
   ,localparam int beats_lp      = line_width_lp/fill_width_p
   ,localparam int lg_els_lp     = (mshr_els_p > 1)
                                   ? $clog2(mshr_els_p) : 1
   ,localparam int lg_words_lp   = (block_size_in_words_p > 1)
                                   ? $clog2(block_size_in_words_p) : 1
   ,localparam int mask_width_lp = word_width_p/8
   )
   (input  logic                      clk_i
   ,input  logic                      reset_i

   ,input  logic                      req_v_i
   ,input  logic [tag_width_p-1:0]    req_tag_i
   ,input  logic [lg_words_lp-1:0]    req_word_i
   ,input  logic [word_width_p-1:0]   req_data_i
   ,input  logic [mask_width_lp-1:0]  req_mask_i
   ,output logic                      req_ready_o
   ,output logic [lg_els_lp-1:0]      req_id_o

   ,output logic                      miss_v_o
   ,output logic [lg_els_lp-1:0]      miss_id_o
   ,output logic [tag_width_p-1:0]    miss_tag_o
   ,input  logic                      miss_yumi_i

   ,input  logic                      fill_v_i
   ,input  logic [lg_els_lp-1:0]      fill_id_i
   ,input  logic [fill_width_p-1:0]   fill_data_i

   ,output logic                      done_v_o
   ,output logic [lg_els_lp-1:0]      done_id_o
   ,output logic [tag_width_p-1:0]    done_tag_o
   ,output logic [line_width_lp-1:0]  done_data_o
   ,input  logic                      done_yumi_i

   ,output logic                      empty_o
   ,output logic                      full_o
`ifdef BSG_CACHE_NB_MSHR_TRACKER_STATS_EN
   ,output logic [31:0]               stat_alloc_o
   ,output logic [31:0]               stat_merge_o
   ,output logic [31:0]               stat_stall_o
`endif
   );

   localparam int line_bytes_lp = line_width_lp/8;
   localparam int fill_bytes_lp = fill_width_p/8;
   localparam int lg_beats_lp   = (beats_lp > 1) ? $clog2(beats_lp) : 1;

   typedef enum logic [2:0] {
      e_idle,
      e_alloc,
      e_pend,
      e_fill,
      e_done
   } state_e;

   state_e                   state_q [mshr_els_p];
   state_e                   state_d [mshr_els_p];
   logic [tag_width_p-1:0]   tag_q   [mshr_els_p];
   logic [tag_width_p-1:0]   tag_d   [mshr_els_p];
   logic [line_width_lp-1:0] data_q  [mshr_els_p];
   logic [line_width_lp-1:0] data_d  [mshr_els_p];
   logic [line_bytes_lp-1:0] vbits_q [mshr_els_p];
   logic [line_bytes_lp-1:0] vbits_d [mshr_els_p];
   logic [lg_beats_lp-1:0]   beat_q;
   logic [lg_beats_lp-1:0]   beat_d;

   logic                 match_v;
   logic [lg_els_lp-1:0] match_id;
   logic                 hold_v;
   logic                 free_v;
   logic [lg_els_lp-1:0] free_id;
   logic [mshr_els_p-1:0] merge_sel;
   logic [mshr_els_p-1:0] fill_sel;
   logic                 fill_ok;
   logic                 last_beat;

   // Lookup and output selection; loops run high to low so the lowest
   // index wins every priority choice.
   always_comb begin
      match_v     = 1'b0;
      match_id    = '0;
      hold_v      = 1'b0;
      free_v      = 1'b0;
      free_id     = '0;
      miss_v_o    = 1'b0;
      miss_id_o   = '0;
      miss_tag_o  = '0;
      done_v_o    = 1'b0;
      done_id_o   = '0;
      done_tag_o  = '0;
      done_data_o = '0;
      empty_o     = 1'b1;
      full_o      = 1'b1;
      for (int i = mshr_els_p-1; i >= 0; i--) begin
         if ((state_q[i] inside {e_alloc, e_pend, e_fill})
             && (tag_q[i] == req_tag_i)) begin
            match_v  = 1'b1;
            match_id = lg_els_lp'(i);
         end
         // A completed line still holding this tag blocks a second
         // allocation until it has been retired.
         if ((state_q[i] == e_done) && (tag_q[i] == req_tag_i)) begin
            hold_v = 1'b1;
         end
         if (state_q[i] == e_idle) begin
            free_v  = 1'b1;
            free_id = lg_els_lp'(i);
            full_o  = 1'b0;
         end else begin
            empty_o = 1'b0;
         end
         if (state_q[i] == e_alloc) begin
            miss_v_o   = 1'b1;
            miss_id_o  = lg_els_lp'(i);
            miss_tag_o = tag_q[i];
         end
         if (state_q[i] == e_done) begin
            done_v_o    = 1'b1;
            done_id_o   = lg_els_lp'(i);
            done_tag_o  = tag_q[i];
            done_data_o = data_q[i];
         end
      end
   end

   assign req_ready_o = req_v_i & ~hold_v & (match_v | free_v);
   assign req_id_o    = match_v ? match_id : free_id;

   always_comb begin
      merge_sel = '0;
      fill_sel  = '0;
      for (int i = 0; i < mshr_els_p; i++) begin
         merge_sel[i] = req_ready_o && (req_id_o == lg_els_lp'(i));
         fill_sel[i]  = fill_v_i && (fill_id_i == lg_els_lp'(i))
                        && (state_q[i] inside {e_pend, e_fill});
      end
   end

   assign fill_ok   = |fill_sel;
   assign last_beat = (beat_q == lg_beats_lp'(beats_lp-1));

   // One line refills at a time, so a single beat counter is shared.
   always_comb begin
      beat_d = beat_q;
      if (fill_ok) begin
         beat_d = last_beat ? '0 : beat_q + 1'b1;
      end
   end

   // Entry next state. Fill bytes land first and only where no store is
   // held; the store merge is applied afterwards so it wins any overlap.
   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      data_d  = data_q;
      vbits_d = vbits_q;
      for (int i = 0; i < mshr_els_p; i++) begin
         unique case (state_q[i])
            e_idle: begin
               if (merge_sel[i] && !match_v) begin
                  state_d[i] = e_alloc;
                  tag_d[i]   = req_tag_i;
                  vbits_d[i] = '0;
               end
            end
            e_alloc: begin
               if (miss_v_o && miss_yumi_i
                   && (miss_id_o == lg_els_lp'(i))) begin
                  state_d[i] = e_pend;
               end
            end
            e_pend, e_fill: begin
               if (fill_sel[i]) begin
                  state_d[i] = last_beat ? e_done : e_fill;
               end
            end
            e_done: begin
               if (done_v_o && done_yumi_i
                   && (done_id_o == lg_els_lp'(i))) begin
                  state_d[i] = e_idle;
                  vbits_d[i] = '0;
               end
            end
            default: state_d[i] = e_idle;
         endcase
         for (int j = 0; j < line_bytes_lp; j++) begin
            if (fill_sel[i]
                && ((j / fill_bytes_lp) == int'(beat_q))
                && !vbits_q[i][j]) begin
               data_d[i][j*8 +: 8] =
                  fill_data_i[(j % fill_bytes_lp)*8 +: 8];
            end
            if (merge_sel[i]
                && ((j / mask_width_lp) == int'(req_word_i))
                && req_mask_i[j % mask_width_lp]) begin
               data_d[i][j*8 +: 8] =
                  req_data_i[(j % mask_width_lp)*8 +: 8];
               vbits_d[i][j] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < mshr_els_p; i++) begin
            state_q[i] <= e_idle;
            tag_q[i]   <= '0;
            data_q[i]  <= '0;
            vbits_q[i] <= '0;
         end
         beat_q <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         vbits_q <= vbits_d;
         beat_q  <= beat_d;
      end
   end

`ifdef BSG_CACHE_NB_MSHR_TRACKER_STATS_EN
   logic [31:0] stat_alloc_q, stat_alloc_d;
   logic [31:0] stat_merge_q, stat_merge_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   // Counters saturate at all-ones instead of wrapping.
   always_comb begin
      stat_alloc_d = stat_alloc_q;
      stat_merge_d = stat_merge_q;
      stat_stall_d = stat_stall_q;
      if (req_ready_o && !match_v && !(&stat_alloc_q)) begin
         stat_alloc_d = stat_alloc_q + 32'd1;
      end
      if (req_ready_o && match_v && !(&stat_merge_q)) begin
         stat_merge_d = stat_merge_q + 32'd1;
      end
      if (req_v_i && !req_ready_o && !(&stat_stall_q)) begin
         stat_stall_d = stat_stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stat_alloc_q <= '0;
         stat_merge_q <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_alloc_q <= stat_alloc_d;
         stat_merge_q <= stat_merge_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_alloc_o = stat_alloc_q;
   assign stat_merge_o = stat_merge_q;
   assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_bsg_cache_nb_mshr_tracker.sv
// tb_bsg_cache_nb_mshr_tracker: directed stimulus with a queue scoreboard;
// a monitor pops expectations on every req/miss/done handshake.
module tb_bsg_cache_nb_mshr_tracker;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          req_v_i = 1'b0;
   logic [25:0]   req_tag_i = '0;
   logic [2:0]    req_word_i = '0;
   logic [31:0]   req_data_i = '0;
   logic [3:0]    req_mask_i = '0;
   logic          req_ready_o;
   logic [1:0]    req_id_o;
   logic          miss_v_o;
   logic [1:0]    miss_id_o;
   logic [25:0]   miss_tag_o;
   logic          miss_yumi_i = 1'b0;
   logic          fill_v_i = 1'b0;
   logic [1:0]    fill_id_i = '0;
   logic [63:0]   fill_data_i = '0;
   logic          done_v_o;
   logic [1:0]    done_id_o;
   logic [25:0]   done_tag_o;
   logic [255:0]  done_data_o;
   logic          done_yumi_i = 1'b0;
   logic          empty_o;
   logic          full_o;
`ifdef BSG_CACHE_NB_MSHR_TRACKER_STATS_EN
   logic [31:0]   stat_alloc_o;
   logic [31:0]   stat_merge_o;
   logic [31:0]   stat_stall_o;
`endif

   bsg_cache_nb_mshr_tracker dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .req_v_i     (req_v_i),
      .req_tag_i   (req_tag_i),
      .req_word_i  (req_word_i),
      .req_data_i  (req_data_i),
      .req_mask_i  (req_mask_i),
      .req_ready_o (req_ready_o),
      .req_id_o    (req_id_o),
      .miss_v_o    (miss_v_o),
      .miss_id_o   (miss_id_o),
      .miss_tag_o  (miss_tag_o),
      .miss_yumi_i (miss_yumi_i),
      .fill_v_i    (fill_v_i),
      .fill_id_i   (fill_id_i),
      .fill_data_i (fill_data_i),
      .done_v_o    (done_v_o),
      .done_id_o   (done_id_o),
      .done_tag_o  (done_tag_o),
      .done_data_o (done_data_o),
      .done_yumi_i (done_yumi_i),
      .empty_o     (empty_o),
      .full_o      (full_o)
`ifdef BSG_CACHE_NB_MSHR_TRACKER_STATS_EN
     ,.stat_alloc_o(stat_alloc_o)
     ,.stat_merge_o(stat_merge_o)
     ,.stat_stall_o(stat_stall_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [1:0]   id;
      logic [25:0]  tag;
      logic [255:0] data;
   } exp_t;

   exp_t q_req[$];
   exp_t q_miss[$];
   exp_t q_done[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [255:0] act,
                        input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event not seen as required", name);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [255:0] pat_line(input logic [7:0] base);
      logic [255:0] l;
      l = '0;
      for (int j = 0; j < 32; j++) l[j*8 +: 8] = base + 8'(j/8);
      return l;
   endfunction

   task automatic req_start(input logic [25:0] tag, input logic [2:0] word,
                            input logic [31:0] data, input logic [3:0] mask,
                            input logic [1:0] id);
      exp_t e;
      e = '0;
      e.id = id;
      q_req.push_back(e);
      req_v_i    = 1'b1;
      req_tag_i  = tag;
      req_word_i = word;
      req_data_i = data;
      req_mask_i = mask;
   endtask

   task automatic req_wait(output int cyc);
      cyc = 0;
      while (cyc < 50) begin
         @(negedge clk_i);
         cyc++;
         if (req_ready_o) break;
      end
      if (!req_ready_o) begin
         fail_now("req_accept_timeout");
         void'(q_req.pop_back());
      end
      step();
      req_v_i = 1'b0;
   endtask

   task automatic req(input logic [25:0] tag, input logic [2:0] word,
                      input logic [31:0] data, input logic [3:0] mask,
                      input logic [1:0] id);
      int c;
      req_start(tag, word, data, mask, id);
      req_wait(c);
   endtask

   task automatic issue_miss(input logic [1:0] id, input logic [25:0] tag);
      exp_t e;
      int   n;
      e = '0;
      e.id = id;
      e.tag = tag;
      q_miss.push_back(e);
      n = 0;
      while (n < 50) begin
         @(negedge clk_i);
         n++;
         if (miss_v_o) break;
      end
      if (!miss_v_o) begin
         fail_now("miss_timeout");
         void'(q_miss.pop_back());
         step();
      end else begin
         miss_yumi_i = 1'b1;
         step();
         miss_yumi_i = 1'b0;
      end
   endtask

   task automatic done_retire(input logic [1:0] id, input logic [25:0] tag,
                              input logic [255:0] line);
      exp_t e;
      int   n;
      e.id = id;
      e.tag = tag;
      e.data = line;
      q_done.push_back(e);
      n = 0;
      while (n < 50) begin
         @(negedge clk_i);
         n++;
         if (done_v_o) break;
      end
      if (!done_v_o) begin
         fail_now("done_timeout");
         void'(q_done.pop_back());
         step();
      end else begin
         done_yumi_i = 1'b1;
         step();
         done_yumi_i = 1'b0;
      end
   endtask

   task automatic fill_beat(input logic [1:0] id, input logic [63:0] d);
      fill_v_i    = 1'b1;
      fill_id_i   = id;
      fill_data_i = d;
      step();
      fill_v_i    = 1'b0;
   endtask

   task automatic fill_line(input logic [1:0] id, input logic [7:0] base);
      for (int k = 0; k < 4; k++) fill_beat(id, {8{base + 8'(k)}});
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         #2;
         if (req_v_i && req_ready_o) begin
            if (q_req.size() == 0) fail_now("req_unexpected");
            else begin
               e = q_req.pop_front();
               check("req_id", req_id_o, e.id);
            end
         end
         if (miss_v_o && miss_yumi_i) begin
            if (q_miss.size() == 0) fail_now("miss_unexpected");
            else begin
               e = q_miss.pop_front();
               check("miss_id", miss_id_o, e.id);
               check("miss_tag", miss_tag_o, e.tag);
            end
         end
         if (done_v_o && done_yumi_i) begin
            if (q_done.size() == 0) fail_now("done_unexpected");
            else begin
               e = q_done.pop_front();
               check("done_id", done_id_o, e.id);
               check("done_tag", done_tag_o, e.tag);
               check("done_data", done_data_o, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] l;
      int           c;

      // Reset
      repeat (3) @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      @(negedge clk_i);
      check("rst_empty", empty_o, 1'b1);
      check("rst_full", full_o, 1'b0);
      check("rst_miss_v", miss_v_o, 1'b0);
      check("rst_done_v", done_v_o, 1'b0);
      check("rst_ready", req_ready_o, 1'b0);
      step();

      // Allocate, merge, refill
      req(26'h100, 3'd2, 32'hDEADBEEF, 4'hF, 2'd0);
      @(negedge clk_i);
      check("a_miss_v", miss_v_o, 1'b1);
      check("a_miss_tag", miss_tag_o, 26'h100);
      check("a_empty", empty_o, 1'b0);
      step();
      req(26'h100, 3'd5, 32'h12345678, 4'h3, 2'd0);
      issue_miss(2'd0, 26'h100);
      @(negedge clk_i);
      check("a_no_second_miss", miss_v_o, 1'b0);
      step();
      for (int k = 0; k < 4; k++) fill_beat(2'd0, 64'hAAAA_AAAA_AAAA_AAAA);
      l = {32{8'hAA}};
      l[64 +: 32]  = 32'hDEADBEEF;
      l[160 +: 16] = 16'h5678;
      done_retire(2'd0, 26'h100, l);
      @(negedge clk_i);
      check("a_empty_after", empty_o, 1'b1);
      step();

      // Fill all entries, stall a fifth tag until id 0 retires
      req(26'h200, 3'd0, 32'h0, 4'h0, 2'd0);
      req(26'h201, 3'd0, 32'h0, 4'h0, 2'd1);
      req(26'h202, 3'd0, 32'h0, 4'h0, 2'd2);
      req(26'h203, 3'd0, 32'h0, 4'h0, 2'd3);
      @(negedge clk_i);
      check("b_full", full_o, 1'b1);
      step();
      issue_miss(2'd0, 26'h200);
      issue_miss(2'd1, 26'h201);
      issue_miss(2'd2, 26'h202);
      issue_miss(2'd3, 26'h203);
      fill_line(2'd0, 8'h01);
      req_start(26'h300, 3'd0, 32'h0, 4'h0, 2'd0);
      @(negedge clk_i);
      check("b_stall_ready", req_ready_o, 1'b0);
      check("b_stall_full", full_o, 1'b1);
      step();
      done_retire(2'd0, 26'h200, pat_line(8'h01));
      req_wait(c);
      check("b_resume_cycles", c, 1);
      issue_miss(2'd0, 26'h300);

      // Same-cycle merge and fill beat 0 on entry 1
      req_start(26'h201, 3'd0, 32'h000000EE, 4'h1, 2'd1);
      fill_v_i    = 1'b1;
      fill_id_i   = 2'd1;
      fill_data_i = 64'h7766554433221100;
      @(negedge clk_i);
      check("c_merge_ready", req_ready_o, 1'b1);
      step();
      req_v_i  = 1'b0;
      fill_v_i = 1'b0;
      fill_beat(2'd1, {8{8'hC1}});
      fill_beat(2'd1, {8{8'hC2}});
      fill_beat(2'd1, {8{8'hC3}});
      l = '0;
      l[0 +: 64]   = 64'h77665544332211EE;
      l[64 +: 64]  = {8{8'hC1}};
      l[128 +: 64] = {8{8'hC2}};
      l[192 +: 64] = {8{8'hC3}};
      done_retire(2'd1, 26'h201, l);

      // Tag matching a DONE entry stalls until retired
      fill_line(2'd2, 8'h20);
      req_start(26'h202, 3'd1, 32'hCAFEF00D, 4'hF, 2'd1);
      @(negedge clk_i);
      check("d_stall_done_tag", req_ready_o, 1'b0);
      step();
      done_retire(2'd2, 26'h202, pat_line(8'h20));
      req_wait(c);
      check("d_resume_cycles", c, 1);
      issue_miss(2'd1, 26'h202);

      // Reset in the middle of a refill
      fill_beat(2'd3, {8{8'h33}});
      fill_beat(2'd3, {8{8'h34}});
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      @(negedge clk_i);
      check("e_empty", empty_o, 1'b1);
      check("e_full", full_o, 1'b0);
      check("e_miss_v", miss_v_o, 1'b0);
      check("e_done_v", done_v_o, 1'b0);
      step();
      req(26'h400, 3'd7, 32'h0BADC0DE, 4'hF, 2'd0);
      issue_miss(2'd0, 26'h400);
      fill_line(2'd0, 8'h50);
      l = pat_line(8'h50);
      l[224 +: 32] = 32'h0BADC0DE;
      done_retire(2'd0, 26'h400, l);
      @(negedge clk_i);
      check("e_empty_end", empty_o, 1'b1);
      check("queues_drained", q_req.size() + q_miss.size() + q_done.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
